pb_debounce_toggle: RTL and testbench

- Upstream stage of the push-button RGB LED driver on the Nexys 4 DDR board.
- Takes the 3 raw, asynchronous, bouncing push-button pins and synchronises and debounces each one.
- Turns each clean press into a toggle of one colour bit.
- Drives a stable 3-bit colour vector into the LED stage: bit0=R, bit1=G, bit2=B, the same index order as that stage's PB input.

---
 rtl/pb_debounce_toggle.sv | 129 ++++++++++++
 tb/tb_pb_debounce_toggle.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce_toggle.sv
// Push-button front end: 2-flop synchroniser, per-button debounce, press-to-toggle colour bits.
// Optional long-press clear of all colour bits is compiled in with `define PB_LONGPRESS_CLEAR_EN.
module pb_debounce_toggle #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb_in,
    output logic [N_BTN-1:0] db_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] led_rgb,
    output logic             long_clear
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] s2_q;
    logic [N_BTN-1:0] db_q;
    logic [N_BTN-1:0] db_d;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] led_q;
    logic [N_BTN-1:0] led_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic             clear_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pb_in;
            s2_q <= s1_q;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples;
    // any matching sample restarts the count.
    always_comb begin
        db_d    = db_q;
        press_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]    = s2_q[i];
                    press_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        led_d = clear_d ? '0 : (led_q ^ press_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q    <= '0;
            press_q <= '0;
            led_q   <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q    <= db_d;
            press_q <= press_d;
            led_q   <= led_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef PB_LONGPRESS_CLEAR_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q [N_BTN];
    logic [HOLD_W-1:0] hold_d [N_BTN];
    logic              long_q;

    // Counters saturate one past the fire value so each hold clears exactly once.
    always_comb begin
        clear_d = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            hold_d[i] = '0;
            if (db_q[i]) begin
                hold_d[i] = (hold_q[i] == HOLD_SAT) ? hold_q[i] : hold_q[i] + 1'b1;
            end
            if (hold_q[i] == HOLD_FIRE) begin
                clear_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_q <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            long_q <= clear_d;
            for (int i = 0; i < N_BTN; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign long_clear = long_q;
`else
    // The long-press threshold has no effect in this build.
    localparam bit LONG_ABOVE_DB = (LONG_CYCLES > DEBOUNCE_CYCLES);

    assign clear_d    = 1'b0;
    assign long_clear = 1'b0 & LONG_ABOVE_DB;
`endif

    assign db_level    = db_q;
    assign press_pulse = press_q;
    assign led_rgb     = led_q;

endmodule

// File: tb/tb_pb_debounce_toggle.sv
// Directed bench for pb_debounce_toggle with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_pb_debounce_toggle;

`ifdef PB_LONGPRESS_CLEAR_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] pb = 3'b000;
    logic [2:0] db_level;
    logic [2:0] press_pulse;
    logic [2:0] led_rgb;
    logic       long_clear;

    int n_cmp = 0;
    int n_fail = 0;

    pb_debounce_toggle #(
        .N_BTN          (3),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pb_in      (pb),
        .db_level   (db_level),
        .press_pulse(press_pulse),
        .led_rgb    (led_rgb),
        .long_clear (long_clear)
    );

    always #5 clk = ~clk;

    task automatic press_release(input logic [2:0] v);
        @(negedge clk);
        pb = v;
        repeat (9) @(negedge clk);
        pb = 3'b000;
        repeat (9) @(negedge clk);
    endtask

    task automatic test_reset_state();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({db_level, press_pulse, led_rgb, long_clear} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: got db=%b pp=%b led=%b lc=%b want all 0", db_level, press_pulse, led_rgb, long_clear);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_press();
        int pulses;
        @(negedge clk);
        pb = 3'b001;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (db_level !== 3'b000) begin
            n_fail++;
            $display("FAIL sp_db_early: got %b want 000", db_level);
        end
        @(negedge clk);
        n_cmp++;
        if ({db_level, press_pulse, led_rgb} !== {3'b001, 3'b001, 3'b001}) begin
            n_fail++;
            $display("FAIL sp_accept: got db=%b pp=%b led=%b want 001/001/001", db_level, press_pulse, led_rgb);
        end
        @(negedge clk);
        n_cmp++;
        if (press_pulse !== 3'b000) begin
            n_fail++;
            $display("FAIL sp_pulse_width: got %b want 000", press_pulse);
        end
        pb = 3'b000;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (press_pulse !== 3'b000) pulses++;
        end
        n_cmp++;
        if ({db_level, led_rgb} !== {3'b000, 3'b001} || pulses != 0) begin
            n_fail++;
            $display("FAIL sp_release: got db=%b led=%b pulses=%0d want 000/001/0", db_level, led_rgb, pulses);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        int dbchg;
        @(negedge clk);
        pb = 3'b010;
        repeat (3) @(negedge clk);
        pb = 3'b000;
        pulses = 0;
        dbchg = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (press_pulse !== 3'b000) pulses++;
            if (db_level !== 3'b000) dbchg++;
        end
        n_cmp++;
        if (pulses != 0 || dbchg != 0) begin
            n_fail++;
            $display("FAIL glitch_filtered: got pulses=%0d db_high_cycles=%0d want 0/0", pulses, dbchg);
        end
        n_cmp++;
        if (led_rgb !== 3'b001) begin
            n_fail++;
            $display("FAIL glitch_led: got %b want 001", led_rgb);
        end
    endtask

    task automatic test_bounce();
        int pat[6] = '{1, 0, 1, 1, 0, 1};
        int p2;
        int other;
        p2 = 0;
        other = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (press_pulse[2]) p2++;
            if (press_pulse[1:0] !== 2'b00) other++;
            pb = (pat[i] == 1) ? 3'b100 : 3'b000;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (press_pulse[2]) p2++;
            if (press_pulse[1:0] !== 2'b00) other++;
        end
        n_cmp++;
        if (p2 != 1 || other != 0) begin
            n_fail++;
            $display("FAIL bounce_pulses: got p2=%0d other=%0d want 1/0", p2, other);
        end
        n_cmp++;
        if ({db_level, led_rgb} !== {3'b100, 3'b101}) begin
            n_fail++;
            $display("FAIL bounce_led: got db=%b led=%b want 100/101", db_level, led_rgb);
        end
        pb = 3'b000;
        repeat (8) @(negedge clk);
        n_cmp++;
        if ({db_level, led_rgb} !== {3'b000, 3'b101}) begin
            n_fail++;
            $display("FAIL bounce_release: got db=%b led=%b want 000/101", db_level, led_rgb);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        logic [2:0] seen;
        press_release(3'b100);
        n_cmp++;
        if (led_rgb !== 3'b001) begin
            n_fail++;
            $display("FAIL sim_setup: got led=%b want 001", led_rgb);
        end
        @(negedge clk);
        pb = 3'b101;
        pulses = 0;
        seen = 3'b000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (press_pulse !== 3'b000) begin
                pulses++;
                seen = press_pulse;
            end
        end
        n_cmp++;
        if (pulses != 1 || seen !== 3'b101) begin
            n_fail++;
            $display("FAIL sim_pulse: got count=%0d value=%b want 1/101", pulses, seen);
        end
        n_cmp++;
        if (led_rgb !== 3'b100) begin
            n_fail++;
            $display("FAIL sim_led: got %b want 100", led_rgb);
        end
        pb = 3'b000;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        pb = 3'b111;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({db_level, press_pulse, led_rgb, long_clear} !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_async: got db=%b pp=%b led=%b lc=%b want all 0", db_level, press_pulse, led_rgb, long_clear);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({db_level, led_rgb} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_held: got db=%b led=%b want 000/000", db_level, led_rgb);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (db_level !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_db_early: got %b want 000", db_level);
        end
        @(negedge clk);
        n_cmp++;
        if ({db_level, press_pulse, led_rgb} !== {3'b111, 3'b111, 3'b111}) begin
            n_fail++;
            $display("FAIL rst_reaccept: got db=%b pp=%b led=%b want 111/111/111", db_level, press_pulse, led_rgb);
        end
        @(negedge clk);
        n_cmp++;
        if ({press_pulse, led_rgb} !== {3'b000, 3'b111}) begin
            n_fail++;
            $display("FAIL rst_after: got pp=%b led=%b want 000/111", press_pulse, led_rgb);
        end
        pb = 3'b000;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_long_press();
        int nclr;
        int clr_idx;
        press_release(3'b001);
        n_cmp++;
        if (led_rgb !== 3'b110) begin
            n_fail++;
            $display("FAIL long_setup: got led=%b want 110", led_rgb);
        end
        @(negedge clk);
        pb = 3'b001;
        nclr = 0;
        clr_idx = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (long_clear) begin
                nclr++;
                clr_idx = i;
            end
            if (i == 6) begin
                n_cmp++;
                if ({press_pulse, led_rgb} !== {3'b001, 3'b111}) begin
                    n_fail++;
                    $display("FAIL long_toggle: got pp=%b led=%b want 001/111", press_pulse, led_rgb);
                end
            end
            if (i == 26) begin
                n_cmp++;
                if ({long_clear, led_rgb} !== (LONG_EN ? 4'b1000 : 4'b0111)) begin
                    n_fail++;
                    $display("FAIL long_fire: got lc=%b led=%b want %b", long_clear, led_rgb, LONG_EN ? 4'b1000 : 4'b0111);
                end
            end
        end
        pb = 3'b000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (long_clear) nclr++;
        end
        n_cmp++;
        if (nclr != (LONG_EN ? 1 : 0) || (LONG_EN && clr_idx != 26)) begin
            n_fail++;
            $display("FAIL long_count: got count=%0d at=%0d want %0d at 26", nclr, clr_idx, LONG_EN ? 1 : 0);
        end
        n_cmp++;
        if (led_rgb !== (LONG_EN ? 3'b000 : 3'b111)) begin
            n_fail++;
            $display("FAIL long_final: got led=%b want %b", led_rgb, LONG_EN ? 3'b000 : 3'b111);
        end
    endtask

    initial begin
        test_reset_state();
        test_single_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset();
        test_long_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
